df_sram_ctrl: RTL
=================

// Module: df_sram_ctrl
// PURPOSE
//  DF-stage data-SRAM access controller, directly upstream of the DF/MEM pipeline register.
//  Decodes load/store ALU ops and drives the data-SRAM port: CE, WE, word address, byte enables, lane-replicated wdata.
//  Inserts WAIT_CYCLES wait states per access by raising a stall request to the pipeline controller.
//  Forwards the GPR write-back fields, byte enables and ALU op to the DF/MEM register.
// PARAMETERS
//  WAIT_CYCLES  0  extra SRAM cycles per access (0..15); stall cycles per memory op
// PORTS
//  CLK            in   1   clock
//  RST            in   1   synchronous reset, active-high
//  FLUSH          in   1   abort the current access (exception/redirect)
//  STALL_DF       in   1   DF stage held by the pipeline controller
//  EX_ALU_OP      in   8   op from EX/DF register
//  EX_GPR_WE      in   1   GPR write enable
//  EX_GPR_WADDR   in   5   GPR destination
//  EX_GPR_WDATA   in   32  ALU result (non-memory ops)
//  EX_MEM_ADDR    in   32  effective byte address
//  EX_MEM_WDATA   in   32  store source register value
//  SRAM_CE        out  1   data-SRAM chip enable, active-high
//  SRAM_WE        out  1   data-SRAM write enable, active-high
//  SRAM_ADDR      out  32  {EX_MEM_ADDR[31:2],2'b00}
//  SRAM_BE        out  4   byte enables, active-low (4'b1111 = none)
//  SRAM_WDATA     out  32  lane-replicated store data
//  STALLREQ_DF    out  1   stall request to the pipeline controller
//  DF_ALU_OP / DF_GPR_WE / DF_GPR_WADDR / DF_GPR_WDATA / DF_SRAM_DATA_BE  out  8/1/5/32/4  to the DF/MEM register
// BEHAVIOUR
//  - Memory ops: LB LBU LH LHU LW SB SH SW. All other ops: CE=0, WE=0, BE=4'b1111, STALLREQ=0.
//  - Lanes, little-endian. Byte: BE bit addr[1:0] low, wdata={4{d[7:0]}}.
//    Half: addr[1]=0 -> 4'b1100, addr[1]=1 -> 4'b0011, wdata={2{d[15:0]}}. Word: 4'b0000, wdata=d.
//  - Pass-through: DF_* = EX_* combinationally; DF_SRAM_DATA_BE = SRAM_BE.
//  - RST asserted (same cycle, combinational): CE=0, WE=0, BE=4'b1111, STALLREQ=0, DF_ALU_OP=NOP, DF_GPR_WE=0.
//    Next edge: state=IDLE, cnt=0.
//  - FSM states IDLE and WAIT; 4-bit counter cnt.
//    IDLE, memory op, WAIT_CYCLES==0: single-cycle access, no stall, stay IDLE.
//    IDLE, memory op, WAIT_CYCLES>0: STALLREQ=1; next state WAIT, cnt=WAIT_CYCLES-1.
//    WAIT, cnt!=0: STALLREQ=1, cnt--.
//    WAIT, cnt==0: STALLREQ=0; next state IDLE. This is the data-valid cycle, captured by DF/MEM.
//  - CE, WE, ADDR, BE and WDATA stay constant for every cycle of one access (inputs held by the stall).
//  - STALL_DF=1 in IDLE: a pending access re-issues each cycle (reads idempotent; the store rewrites the same data).
//    STALL_DF=1 in WAIT: the counter keeps counting.
//  - FLUSH (priority over all except RST): same cycle CE=0, WE=0, STALLREQ=0, DF_GPR_WE=0, DF_ALU_OP=NOP.
//    Next state IDLE, cnt=0. FLUSH in WAIT aborts the access.
//  - A new memory op arriving on the cycle after WAIT->IDLE starts a fresh access; no bubble.
// CONFIGURATION
//  - `DF_ADDR_EXC_EN defined: misaligned access (half with addr[0]=1, word with addr[1:0]!=0) suppresses the access:
//    CE=0, WE=0, no stall, DF_GPR_WE=0.
//    Adds outputs DF_ADEL (misaligned load) and DF_ADES (misaligned store), 1 bit each, reset 0.
//  - Not defined: addr low bits ignored per width (half uses addr[1], word uses none); no ADEL/ADES ports.
// STRUCTURE
//  - Package df_pkg: state enum (IDLE, WAIT), memory-op decode constants, lane-code localparams, NOP op value.
//  - Sub-module df_lane_gen: combinational BE/wdata generator from {op, addr[1:0], data}.
//  - Top: FSM + counter + output muxing.
// TESTING
//  1. WAIT_CYCLES=0, SW addr=0x100, d=0x11223344 -> CE=1, WE=1, BE=4'b0000, ADDR=0x100, STALLREQ=0 for one cycle.
//  2. WAIT_CYCLES=2, LW addr=0x40 -> STALLREQ=1 for exactly 2 cycles; CE=1 for 3 cycles; addr stable; then IDLE.
//  3. SB addr=0x103, d=0xAB -> BE=4'b0111, WDATA=0xABABABAB. SH addr=0x102, d=0xBEEF -> BE=4'b0011, WDATA=0xBEEFBEEF.
//  4. WAIT_CYCLES=3, FLUSH in the 2nd stall cycle -> CE=0 and STALLREQ=0 that cycle; IDLE next; next LW gets full 3 stalls.
//  5. RST asserted mid-WAIT -> CE=0, STALLREQ=0 immediately; state IDLE after the edge.
//  6. `DF_ADDR_EXC_EN, LW addr=0x102 -> DF_ADEL=1, CE=0, DF_GPR_WE=0. Without the macro: ADDR=0x100, BE=4'b0000.

Source files
------------

// File: rtl/df_sram_ctrl_pkg.sv
// df_pkg: shared state enum, memory-op codes, lane codes and op decode helpers for the DF-stage SRAM controller
package df_pkg;

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LB  = 8'he0;
    localparam logic [7:0] OP_LH  = 8'he1;
    localparam logic [7:0] OP_LW  = 8'he3;
    localparam logic [7:0] OP_LBU = 8'he4;
    localparam logic [7:0] OP_LHU = 8'he5;
    localparam logic [7:0] OP_SB  = 8'he8;
    localparam logic [7:0] OP_SH  = 8'he9;
    localparam logic [7:0] OP_SW  = 8'heb;

    localparam logic [1:0] LANE_NONE = 2'd0;
    localparam logic [1:0] LANE_B    = 2'd1;
    localparam logic [1:0] LANE_H    = 2'd2;
    localparam logic [1:0] LANE_W    = 2'd3;

    function automatic logic [1:0] op_lane(input logic [7:0] op);
        return (op == OP_LB || op == OP_LBU || op == OP_SB) ? LANE_B :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? LANE_H :
               (op == OP_LW || op == OP_SW)                 ? LANE_W : LANE_NONE;
    endfunction

    function automatic logic op_store(input logic [7:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

endpackage

// File: rtl/df_sram_ctrl_lane_gen.sv
// df_lane_gen: active-low byte enables and lane-replicated write data from op width and address low bits
module df_lane_gen
    import df_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    logic [1:0] lane;
    assign lane = op_lane(op);

    // Little-endian lane select; non-memory ops enable no bytes
    always_comb begin
        be    = lane == LANE_B ? ~(4'b0001 << addr_lo) :
                lane == LANE_H ? (addr_lo[1] ? 4'b0011 : 4'b1100) :
                lane == LANE_W ? 4'b0000 : 4'b1111;
        wdata = lane == LANE_B ? {4{data[7:0]}} :
                lane == LANE_H ? {2{data[15:0]}} : data;
    end

endmodule

// File: rtl/df_sram_ctrl.sv
// df_sram_ctrl: DF-stage data-SRAM access controller with wait-state stalls; `DF_ADDR_EXC_EN adds misalignment exceptions
module df_sram_ctrl
    import df_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        STALL_DF,
    input  logic [7:0]  EX_ALU_OP,
    input  logic        EX_GPR_WE,
    input  logic [4:0]  EX_GPR_WADDR,
    input  logic [31:0] EX_GPR_WDATA,
    input  logic [31:0] EX_MEM_ADDR,
    input  logic [31:0] EX_MEM_WDATA,
    output logic        SRAM_CE,
    output logic        SRAM_WE,
    output logic [31:0] SRAM_ADDR,
    output logic [3:0]  SRAM_BE,
    output logic [31:0] SRAM_WDATA,
    output logic        STALLREQ_DF,
    output logic [7:0]  DF_ALU_OP,
    output logic        DF_GPR_WE,
    output logic [4:0]  DF_GPR_WADDR,
    output logic [31:0] DF_GPR_WDATA,
`ifdef DF_ADDR_EXC_EN
    output logic        DF_ADEL,
    output logic        DF_ADES,
`endif
    output logic [3:0]  DF_SRAM_DATA_BE
);

    localparam logic [3:0] CNT_INIT = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t     state, next_state;
    logic [3:0] cnt, next_cnt;
    logic [1:0] lane;
    logic [3:0] lane_be;
    logic       kill, store, misal, access, fsm_ce, fsm_stall;
    logic       stall_df_unused;

    // The stage hold needs no handling: an IDLE access simply re-issues and WAIT keeps counting
    assign stall_df_unused = STALL_DF;

    assign lane  = op_lane(EX_ALU_OP);
    assign store = op_store(EX_ALU_OP);
    assign kill  = RST || FLUSH;

`ifdef DF_ADDR_EXC_EN
    assign misal   = (lane == LANE_H && EX_MEM_ADDR[0]) || (lane == LANE_W && EX_MEM_ADDR[1:0] != 2'b00);
    assign DF_ADEL = !kill && misal && !store;
    assign DF_ADES = !kill && misal && store;
`else
    assign misal = 1'b0;
`endif

    assign access = lane != LANE_NONE && !misal;

    df_lane_gen u_lane (
        .op      (EX_ALU_OP),
        .addr_lo (EX_MEM_ADDR[1:0]),
        .data    (EX_MEM_WDATA),
        .be      (lane_be),
        .wdata   (SRAM_WDATA)
    );

    // State and wait counter register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next state, counter and access/stall strobes; reset and flush abort any access
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        fsm_ce     = 1'b0;
        fsm_stall  = 1'b0;
        if (kill) begin
            next_state = IDLE;
            next_cnt   = '0;
        end else if (state == IDLE) begin
            fsm_ce = access;
            if (access && WAIT_CYCLES != 0) begin
                fsm_stall  = 1'b1;
                next_state = WAIT;
                next_cnt   = CNT_INIT;
            end
        end else begin
            fsm_ce     = access;
            fsm_stall  = cnt != 4'd0;
            next_cnt   = cnt != 4'd0 ? cnt - 4'd1 : cnt;
            next_state = cnt != 4'd0 ? WAIT : IDLE;
        end
    end

    assign SRAM_CE         = fsm_ce;
    assign SRAM_WE         = fsm_ce && store;
    assign SRAM_ADDR       = {EX_MEM_ADDR[31:2], 2'b00};
    assign SRAM_BE         = fsm_ce ? lane_be : 4'b1111;
    assign STALLREQ_DF     = fsm_stall;
    assign DF_ALU_OP       = kill ? OP_NOP : EX_ALU_OP;
    assign DF_GPR_WE       = EX_GPR_WE && !kill && !misal;
    assign DF_GPR_WADDR    = EX_GPR_WADDR;
    assign DF_GPR_WDATA    = EX_GPR_WDATA;
    assign DF_SRAM_DATA_BE = SRAM_BE;

endmodule
